// File: rtl/qmux_arb_pkg.sv
// Shared types and constants for the quad 2:1 mux arbiter.
// State encoding, owner identifiers (which double as mux select values)
// and the round-robin helper used by the arbiter FSM.
package qmux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Owner identifiers; the value is also the S level that routes that owner to Y.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Round-robin: whoever did not own the bus last wins a contention.
  function automatic logic rr_winner(input logic last_owner);
    return ~last_owner;
  endfunction

endpackage

// File: rtl/Mux2to1_4bit.sv
// Quad 2-to-1 multiplexer datapath with active-high disable.
// Y = E ? 4'b0000 : (S ? B : A).
module Mux2to1_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       S,
  input  logic       E,
  output logic [3:0] Y
);

  // Disable forces the shared bus low; otherwise route the selected input.
  always_comb begin
    Y = 4'b0000;
    if (!E) begin
      Y = S ? B : A;
    end
  end

endmodule

// File: rtl/quad_mux_arbiter.sv
// Two-requester round-robin arbiter driving a quad 2:1 mux onto a shared Y bus.
// A grant is held while the owner keeps requesting; every handover passes
// through one disabled GAP cycle (break-before-make). S and E come from
// registered state, Y is combinational from them and the live A/B data.
// Optional feature macro: QMUX_ARB_TIMEOUT_EN adds the hold counter that
// preempts an owner after HOLD_MAX cycles while the other side waits.
module quad_mux_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       S,
  output logic       E,
  output logic [3:0] Y,
  output logic       BUSY
);

  import qmux_arb_pkg::*;

  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("quad_mux_arbiter: HOLD_MAX must be at least 1");
  end

  arb_state_t state_reg, state_next;
  logic       last_reg, last_next;
  logic       s_reg, s_next;

  logic       winner;
  logic       own_req;
  logic       other_req;
  logic       hold_expired;
  logic       in_own;

  assign winner    = rr_winner(last_reg);
  assign in_own    = (state_reg == OWN_A) || (state_reg == OWN_B);
  // Request lines seen from the current owner's point of view.
  assign own_req   = (state_reg == OWN_B) ? REQ_B : REQ_A;
  assign other_req = (state_reg == OWN_B) ? REQ_A : REQ_B;

`ifdef QMUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  assign hold_expired = (cnt_reg == CNT_MAX);

  // Hold counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Count cycles spent in the same OWN state; zero on entry and outside OWN,
  // saturating so a lone owner can keep the bus indefinitely.
  always_comb begin
    cnt_next = '0;
    if (in_own && (state_next == state_reg)) begin
      cnt_next = hold_expired ? cnt_reg : cnt_reg + 1'b1;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // FSM, last-owner pointer and select register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      last_reg  <= OWNER_B;
      s_reg     <= OWNER_A;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      s_reg     <= s_next;
    end
  end

  // Next-state logic; a grant sets the new state, LAST and S together.
  always_comb begin
    logic take;
    logic take_id;
    state_next = state_reg;
    last_next  = last_reg;
    s_next     = s_reg;
    take       = 1'b0;
    take_id    = OWNER_A;
    case (state_reg)
      IDLE: begin
        if (REQ_A && REQ_B) begin
          take    = 1'b1;
          take_id = winner;
        end else if (REQ_A) begin
          take    = 1'b1;
          take_id = OWNER_A;
        end else if (REQ_B) begin
          take    = 1'b1;
          take_id = OWNER_B;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req) begin
          state_next = other_req ? GAP : IDLE;
        end else if (other_req && hold_expired) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if ((winner == OWNER_B) ? REQ_B : REQ_A) begin
          take    = 1'b1;
          take_id = winner;
        end else if ((last_reg == OWNER_B) ? REQ_B : REQ_A) begin
          take    = 1'b1;
          take_id = last_reg;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (take) begin
      state_next = (take_id == OWNER_B) ? OWN_B : OWN_A;
      last_next  = take_id;
      s_next     = take_id;
    end
  end

  assign GNT_A = (state_reg == OWN_A);
  assign GNT_B = (state_reg == OWN_B);
  assign E     = ~in_own;
  assign S     = s_reg;
  assign BUSY  = (state_reg != IDLE);

  Mux2to1_4bit u_mux (
    .A (A),
    .B (B),
    .S (S),
    .E (E),
    .Y (Y)
  );

endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Scoreboard bench for quad_mux_arbiter: the driver steps a behavioural
// ownership model and queues the expected outputs; a monitor on the falling
// edge pops and compares them. Follows QMUX_ARB_TIMEOUT_EN like the design.
module tb_quad_mux_arbiter;

  localparam int HOLD_MAX = 4;
`ifdef QMUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [3:0] a, b, y;
  logic       gnt_a, gnt_b, s, e, busy;

  always #5 clk = ~clk;

  quad_mux_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .CLK   (clk),
    .RST   (rst),
    .REQ_A (req_a),
    .REQ_B (req_b),
    .A     (a),
    .B     (b),
    .GNT_A (gnt_a),
    .GNT_B (gnt_b),
    .S     (s),
    .E     (e),
    .Y     (y),
    .BUSY  (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected {gnt_a, gnt_b, s, e, busy, y}
  logic [8:0] exp_q[$];

  // Behavioural model: who owns the bus (-1 = nobody), whether a handover
  // gap is in progress, who owned last, current select, cycles owned so far.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_last  = 1;
  bit m_s     = 1'b0;
  int m_held  = 0;

  function automatic bit req_of(input int who, input bit ra, input bit rb);
    return (who == 1) ? rb : ra;
  endfunction

  task automatic take(input int who);
    m_owner = who;
    m_last  = who;
    m_s     = (who == 1);
    m_held  = 1;
  endtask

  task automatic model_step(input bit r, input bit ra, input bit rb);
    bit mine, other;
    int w;
    if (r) begin
      m_owner = -1; m_gap = 1'b0; m_last = 1; m_s = 1'b0; m_held = 0;
    end else if (m_owner >= 0) begin
      mine  = req_of(m_owner, ra, rb);
      other = req_of(1 - m_owner, ra, rb);
      if (!mine) begin
        m_owner = -1;
        m_gap   = other;
      end else if (other && TIMEOUT_EN && (m_held >= HOLD_MAX)) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      w = 1 - m_last;
      if (m_gap) begin
        m_gap = 1'b0;
        if (req_of(w, ra, rb)) take(w);
        else if (req_of(m_last, ra, rb)) take(m_last);
      end else if (ra && rb) take(w);
      else if (ra) take(0);
      else if (rb) take(1);
    end
  endtask

  // One clock: the edge samples the current inputs, then new ones are applied.
  task automatic cycle(input bit r, input bit ra, input bit rb,
                       input logic [3:0] na, input logic [3:0] nb);
    bit pr, pa, pb, xe;
    logic [3:0] xy;
    pr = rst; pa = req_a; pb = req_b;
    @(posedge clk);
    #1;
    model_step(pr, pa, pb);
    rst = r; req_a = ra; req_b = rb; a = na; b = nb;
    xe = (m_owner < 0);
    xy = xe ? 4'b0000 : (m_s ? nb : na);
    exp_q.push_back({m_owner == 0, m_owner == 1, m_s, xe, (m_owner >= 0) || m_gap, xy});
  endtask

  task automatic run(input int n, input bit r, input bit ra, input bit rb);
    for (int i = 0; i < n; i++) cycle(r, ra, rb, 4'b1010, 4'b0011);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    logic [8:0] xv, gv;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        xv = exp_q.pop_front();
        gv = {gnt_a, gnt_b, s, e, busy, y};
        cyc++;
        checks++;
        if (gv !== xv) begin
          failures++;
          $display("FAIL outputs cycle=%0d got{ga,gb,s,e,busy,y}=%b expected=%b rst=%b req_a=%b req_b=%b",
                   cyc, gv, xv, rst, req_a, req_b);
        end
        checks++;
        if ((gnt_a && gnt_b) || (e !== !(gnt_a ^ gnt_b))) begin
          failures++;
          $display("FAIL invariant cycle=%0d got ga=%b gb=%b e=%b required exclusive grants and e=!grant",
                   cyc, gnt_a, gnt_b, e);
        end
      end
    end
  end

  initial begin
    bit r, ra, rb;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; a = 4'b1010; b = 4'b0000;
    // Reset held two edges with both requesting, then A wins.
    cycle(1'b1, 1'b1, 1'b1, 4'b1010, 4'b0000);
    run(4, 1'b0, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);
    // Single requester B, then release straight to idle.
    run(5, 1'b0, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);
    // Handover A -> B via one gap cycle.
    run(3, 1'b0, 1'b1, 1'b0);
    run(2, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);
    // Reset while B owns, then contention goes to A.
    run(3, 1'b0, 1'b0, 1'b1);
    run(1, 1'b1, 1'b0, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    // Continuous contention: preemption or indefinite hold.
    run(24, 1'b0, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);
    // Randomized level-style requests with occasional reset.
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      r = ($urandom_range(0, 99) == 0);
      cycle(r, ra, rb, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    run(2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
